// File: rtl/score_collector.sv
// score_collector
//
// Collects ENTRIES score/position pairs from a square evaluator into a flat register
// bank. The bank feeds a downstream arbiter. Slot k of both output buses drives arbiter
// input k+1, so slots 0..63 drive in1..in64 and inpos_1..inpos_64.
//
// States:
//   IDLE - bank_valid is low. Slots keep their last contents.
//   LOAD - accepts pairs. On each accept the pair is written to slot[count] and count
//          advances.
//   FULL - all slots are loaded. bank_valid is high and the bank is frozen until the
//          consumer asserts bank_ack.
//
// Ports:
//   clk, rst     single clock; synchronous active-high reset
//   start        begins a new pass (from IDLE, restarts in LOAD, or from FULL with bank_ack)
//   in_valid     evaluator presents in_score / in_pos
//   in_ready     high in LOAD
//   in_score     score for one square
//   in_pos       position tag for that score
//   in_legal     (SCORE_MASK_EN only) when low, the stored score is forced to 0
//   scores_flat  stored scores, slot k at [k*SCORE_W +: SCORE_W]
//   pos_flat     stored positions, same packing
//   bank_valid   all slots are loaded and the arbiter result is meaningful
//   bank_ack     consumer has latched the arbiter result
//   busy         a collection pass is in progress (LOAD)
//   count        pairs accepted in the current pass; saturates at ENTRIES
//
// Configuration macro: SCORE_MASK_EN adds in_legal and score masking on accept.
// ENTRIES must not exceed 127 so that it fits in the 7-bit count.

module score_collector #(
  parameter int unsigned SCORE_W = 6,
  parameter int unsigned ENTRIES = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SCORE_W-1:0]         in_score,
  input  logic [SCORE_W-1:0]         in_pos,
`ifdef SCORE_MASK_EN
  input  logic                       in_legal,
`endif
  output logic [ENTRIES*SCORE_W-1:0] scores_flat,
  output logic [ENTRIES*SCORE_W-1:0] pos_flat,
  output logic                       bank_valid,
  input  logic                       bank_ack,
  output logic                       busy,
  output logic [6:0]                 count
);

  localparam int unsigned BankW = ENTRIES * SCORE_W;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StFull
  } state_e;

  state_e             state_q, state_d;
  logic [6:0]         count_q, count_d;
  logic [BankW-1:0]   scores_q, scores_d;
  logic [BankW-1:0]   pos_q, pos_d;

  logic               accept;
  logic               last_accept;
  logic [SCORE_W-1:0] store_score;

  // Outputs are decoded from the state register only, so they never glitch on inputs.
  assign in_ready   = (state_q == StLoad);
  assign busy       = (state_q == StLoad);
  assign bank_valid = (state_q == StFull);

  assign count       = count_q;
  assign scores_flat = scores_q;
  assign pos_flat    = pos_q;

  assign accept      = in_valid && in_ready;
  assign last_accept = (count_q == 7'(ENTRIES - 1));

`ifdef SCORE_MASK_EN
  // An illegal square stores score 0. Its position tag is still recorded.
  assign store_score = in_legal ? in_score : '0;
`else
  assign store_score = in_score;
`endif

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    scores_d = scores_q;
    pos_d    = pos_q;

    unique case (state_q)
      StIdle: begin
        // Clearing on entry keeps a new pass from ever exposing stale scores.
        if (start) begin
          state_d  = StLoad;
          count_d  = '0;
          scores_d = '0;
          pos_d    = '0;
        end
      end

      StLoad: begin
        if (start) begin
          // A restart wins over a same-cycle accept, so that pair is dropped.
          count_d  = '0;
          scores_d = '0;
          pos_d    = '0;
        end else if (accept) begin
          for (int unsigned k = 0; k < ENTRIES; k++) begin
            if (count_q == 7'(k)) begin
              scores_d[k*SCORE_W +: SCORE_W] = store_score;
              pos_d[k*SCORE_W +: SCORE_W]    = in_pos;
            end
          end
          count_d = count_q + 7'd1;
          if (last_accept) begin
            state_d = StFull;
          end
        end
      end

      StFull: begin
        // Without bank_ack, start is ignored and the bank stays frozen.
        if (bank_ack) begin
          if (start) begin
            state_d  = StLoad;
            count_d  = '0;
            scores_d = '0;
            pos_d    = '0;
          end else begin
            state_d = StIdle;
          end
        end
      end

      default: begin
        state_d = StIdle;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      count_q  <= '0;
      scores_q <= '0;
      pos_q    <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      scores_q <= scores_d;
      pos_q    <= pos_d;
    end
  end

endmodule

// File: tb/tb_score_collector.sv
module tb_score_collector;

  localparam int SW = 6;
  localparam int NE = 64;
  localparam int BW = SW * NE;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] in_score;
  logic [SW-1:0] in_pos;
`ifdef SCORE_MASK_EN
  logic          in_legal;
`endif
  logic [BW-1:0] scores_flat;
  logic [BW-1:0] pos_flat;
  logic          bank_valid;
  logic          bank_ack;
  logic          busy;
  logic [6:0]    count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [BW-1:0] exp_s;
  logic [BW-1:0] exp_p;

  always #5 clk = ~clk;

  score_collector #(.SCORE_W(SW), .ENTRIES(NE)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_score   (in_score),
    .in_pos     (in_pos),
`ifdef SCORE_MASK_EN
    .in_legal   (in_legal),
`endif
    .scores_flat(scores_flat),
    .pos_flat   (pos_flat),
    .bank_valid (bank_valid),
    .bank_ack   (bank_ack),
    .busy       (busy),
    .count      (count)
  );

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start    = 1'b0;
    in_valid = 1'b0;
    bank_ack = 1'b0;
    in_score = '0;
    in_pos   = '0;
  endtask

  initial begin
    rst = 1'b1;
`ifdef SCORE_MASK_EN
    in_legal = 1'b1;
`endif
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_bank_valid", bank_valid, 0);
    check("rst_count", count, 0);
    check("rst_scores", scores_flat, 0);
    check("rst_pos", pos_flat, 0);

    // In IDLE, in_valid is ignored
    in_valid = 1'b1; in_score = 6'h3F; in_pos = 6'h3F;
    tick();
    in_valid = 1'b0;
    check("idle_ignore_scores", scores_flat, 0);
    check("idle_ignore_count", count, 0);

    // Full pass with score=k, pos=k
    start = 1'b1;
    tick();
    start = 1'b0;
    check("load_busy", busy, 1);
    check("load_in_ready", in_ready, 1);
    check("load_count0", count, 0);
    exp_s = '0;
    exp_p = '0;
    for (int k = 0; k < NE; k++) begin
      in_valid = 1'b1; in_score = SW'(k); in_pos = SW'(k);
      exp_s[k*SW +: SW] = SW'(k);
      exp_p[k*SW +: SW] = SW'(k);
      tick();
      if (k == NE - 2) begin
        check("p1_not_full_63", bank_valid, 0);
        check("p1_count_63", count, 63);
      end
    end
    in_valid = 1'b0;
    check("p1_bank_valid", bank_valid, 1);
    check("p1_in_ready", in_ready, 0);
    check("p1_busy", busy, 0);
    check("p1_count", count, 64);
    check("p1_slot63_score", scores_flat[63*SW +: SW], 63);
    check("p1_slot63_pos", pos_flat[63*SW +: SW], 63);
    check("p1_scores", scores_flat, exp_s);
    check("p1_pos", pos_flat, exp_p);

    // In FULL, in_valid and a lone start are ignored
    in_valid = 1'b1; in_score = 6'h3F; in_pos = 6'h3F;
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("full_hold_scores", scores_flat, exp_s);
    check("full_hold_pos", pos_flat, exp_p);
    check("full_in_ready", in_ready, 0);
    check("full_bank_valid", bank_valid, 1);
    check("full_count", count, 64);
    bank_ack = 1'b1;
    tick();
    bank_ack = 1'b0;
    in_valid = 1'b0;
    check("ack_bank_valid", bank_valid, 0);
    check("ack_busy", busy, 0);
    check("ack_retain_scores", scores_flat, exp_s);

    // Pass with in_valid toggling; odd cycles carry the pair, even cycles carry junk
    start = 1'b1;
    tick();
    start = 1'b0;
    check("p2_cleared", scores_flat, 0);
    exp_s = '0;
    exp_p = '0;
    for (int i = 0; i < 2 * NE; i++) begin
      if (i % 2 == 1) begin
        in_valid = 1'b1;
        in_score = SW'(63 - i / 2);
        in_pos   = SW'(i / 2);
        exp_s[(i / 2)*SW +: SW] = SW'(63 - i / 2);
        exp_p[(i / 2)*SW +: SW] = SW'(i / 2);
      end else begin
        in_valid = 1'b0;
        in_score = 6'h2A;
        in_pos   = 6'h15;
      end
      if (i == NE) begin
        check("p2_no_full_at_64_cycles", bank_valid, 0);
        check("p2_count_at_64_cycles", count, 32);
      end
      tick();
      if (i == 2 * NE - 2) begin
        check("p2_not_full_63", bank_valid, 0);
      end
    end
    in_valid = 1'b0;
    check("p2_bank_valid", bank_valid, 1);
    check("p2_count", count, 64);
    check("p2_scores", scores_flat, exp_s);
    check("p2_pos", pos_flat, exp_p);

    // start together with bank_ack in FULL: straight back to LOAD
    start = 1'b1; bank_ack = 1'b1;
    tick();
    start = 1'b0; bank_ack = 1'b0;
    check("full_restart_busy", busy, 1);
    check("full_restart_valid", bank_valid, 0);
    check("full_restart_count", count, 0);

    // Restart mid-pass after 10 accepts, with a same-cycle pair that must be dropped
    exp_s = '0;
    exp_p = '0;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_score = SW'(k + 1); in_pos = SW'(k + 2);
      exp_s[k*SW +: SW] = SW'(k + 1);
      exp_p[k*SW +: SW] = SW'(k + 2);
      tick();
    end
    check("r10_count", count, 10);
    check("r10_scores", scores_flat, exp_s);
    check("r10_pos", pos_flat, exp_p);
    start = 1'b1; in_valid = 1'b1; in_score = 6'h05; in_pos = 6'h07;
    tick();
    start = 1'b0;
    check("restart_count", count, 0);
    check("restart_scores", scores_flat, 0);
    check("restart_pos", pos_flat, 0);
    check("restart_busy", busy, 1);
    in_score = 6'h11; in_pos = 6'h22;
    tick();
    in_valid = 1'b0;
    check("restart_first_count", count, 1);
    check("restart_first_scores", scores_flat, BW'(6'h11));
    check("restart_first_pos", pos_flat, BW'(6'h22));

    // Reset in the middle of a pass, with start/in_valid/bank_ack all high
    for (int k = 1; k < 30; k++) begin
      in_valid = 1'b1; in_score = SW'(k); in_pos = SW'(k);
      tick();
    end
    check("pre_rst_count", count, 30);
    rst = 1'b1; start = 1'b1; in_valid = 1'b1; bank_ack = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    check("mid_rst_count", count, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_bank_valid", bank_valid, 0);
    check("mid_rst_scores", scores_flat, 0);
    check("mid_rst_pos", pos_flat, 0);

    // Normal pass after reset
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_s = '0;
    exp_p = '0;
    for (int k = 0; k < NE; k++) begin
      in_valid = 1'b1;
      in_score = SW'(k) ^ 6'h15;
      in_pos   = SW'(63 - k);
      exp_s[k*SW +: SW] = SW'(k) ^ 6'h15;
      exp_p[k*SW +: SW] = SW'(63 - k);
      tick();
    end
    in_valid = 1'b0;
    check("p3_bank_valid", bank_valid, 1);
    check("p3_count", count, 64);
    check("p3_scores", scores_flat, exp_s);
    check("p3_pos", pos_flat, exp_p);
    bank_ack = 1'b1;
    tick();
    bank_ack = 1'b0;
    check("p3_ack", bank_valid, 0);

`ifdef SCORE_MASK_EN
    // Masking: illegal square stores score 0, legal square stores score verbatim
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_score = 6'd50; in_pos = 6'd9; in_legal = 1'b0;
    tick();
    in_pos = 6'd12; in_legal = 1'b1;
    tick();
    in_valid = 1'b0;
    check("mask_slot0_score", scores_flat[0 +: SW], 0);
    check("mask_slot0_pos", pos_flat[0 +: SW], 9);
    check("mask_slot1_score", scores_flat[SW +: SW], 50);
    check("mask_slot1_pos", pos_flat[SW +: SW], 12);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
